sample_iter_ctrl: RTL and testbench

- Sequencer in front of the sample-test stage.
- Accepts one triangle plus its pre-computed bounding box and walks the sample grid inside the box, row-major.
- Emits SAMPS horizontally adjacent sample positions per cycle, with per-lane valid flags, along with the held triangle and colour.
- Applies upstream halt and downstream stall so the sample-test pipe never drops or duplicates a sample group.

---
 rtl/sample_iter_ctrl_if.sv | 32 +++
 rtl/sample_iter_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sample_iter_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_iter_ctrl_if.sv
// Bundles the triangle-in / sample-group-out signals of the sample iterator.
// The iterator sits on the slave modport; the feeding stage uses master.
interface sample_iter_ctrl_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic [1:0]                             ss_lg2_R13U;
    logic                                   validTri_R13H;
    logic                                   halt_R13H;
    logic                                   stall_R14H;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [SAMPS-1:0][1:0][SIGFIG-1:0]      sample_R14S;
    logic [SAMPS-1:0]                       validSamp_R14H;
    logic                                   lastSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, ss_lg2_R13U, validTri_R13H, stall_R14H,
        input  halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H, lastSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, ss_lg2_R13U, validTri_R13H, stall_R14H,
        output halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H, lastSamp_R14H
    );
endinterface

// File: rtl/sample_iter_ctrl.sv
// Walks the sample grid inside a triangle's bounding box, row-major, SAMPS
// horizontally adjacent samples per cycle, with halt/stall flow control.
module sample_iter_ctrl #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    sample_iter_ctrl_if.slave bus
);
    localparam int W        = SIGFIG + 1;
    localparam int LG_SAMPS = (SAMPS > 1) ? $clog2(SAMPS) : 0;

    typedef logic signed [W-1:0] wide_t;
    typedef logic [SIGFIG-1:0]   word_t;
    typedef enum logic {ST_WAIT = 1'b0, ST_TEST = 1'b1} state_t;

    // One extra sign bit keeps every compare/add free of wrap at the range edge.
    function automatic wide_t sext(input word_t v);
        return $signed({v[SIGFIG-1], v});
    endfunction

    function automatic wide_t grp_span(input word_t st);
        return sext(st) <<< LG_SAMPS;
    endfunction

    state_t state_q, state_d;
    word_t  cur_x_q, cur_x_d;
    word_t  cur_y_q, cur_y_d;
    word_t  ll_x_q, ll_x_d;
    word_t  ur_x_q, ur_x_d;
    word_t  ur_y_q, ur_y_d;
    word_t  step_q, step_d;

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic [SAMPS-1:0][1:0][SIGFIG-1:0]      sample_q, sample_d;
    logic [SAMPS-1:0]                       valid_q, valid_d;
    logic                                   last_q, last_d;

    word_t new_step;
    word_t step_mask;
    word_t snap_x;
    word_t snap_y;
    logic  box_empty;
    logic  halt;
    logic  accept;
    logic  advance;
    logic  row_end;
    wide_t lane_x [SAMPS];

    // Snapping by masking floors toward minus infinity for negative coordinates too.
    always_comb begin
        new_step  = word_t'(1) << (RADIX - int'(bus.ss_lg2_R13U));
        step_mask = ~(new_step - word_t'(1));
        snap_x    = bus.box_R13S[0][0] & step_mask;
        snap_y    = bus.box_R13S[0][1] & step_mask;
        box_empty = (sext(bus.box_R13S[1][0]) < sext(snap_x)) ||
                    (sext(bus.box_R13S[1][1]) < sext(snap_y));
    end

    // Halt drops while the last group is being consumed so the next triangle
    // can be taken on the same edge.
    assign halt    = (state_q == ST_TEST) && !(last_q && !bus.stall_R14H);
    assign accept  = bus.validTri_R13H && !halt;
    assign advance = (state_q == ST_TEST) && !bus.stall_R14H;
    assign row_end = (sext(cur_x_q) + grp_span(step_q)) > sext(ur_x_q);

    // State register, iterator and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_WAIT;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            ll_x_q   <= '0;
            ur_x_q   <= '0;
            ur_y_q   <= '0;
            step_q   <= '0;
            tri_q    <= '0;
            color_q  <= '0;
            sample_q <= '0;
            valid_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            ll_x_q   <= ll_x_d;
            ur_x_q   <= ur_x_d;
            ur_y_q   <= ur_y_d;
            step_q   <= step_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    // Next-state and iterator advance
    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        ll_x_d  = ll_x_q;
        ur_x_d  = ur_x_q;
        ur_y_d  = ur_y_q;
        step_d  = step_q;
        tri_d   = tri_q;
        color_d = color_q;

        if (advance) begin
            if (last_q) begin
                state_d = ST_WAIT;
            end else if (row_end) begin
                cur_x_d = ll_x_q;
                cur_y_d = cur_y_q + step_q;
            end else begin
                cur_x_d = cur_x_q + word_t'(grp_span(step_q));
            end
        end

        // An accepted triangle overrides the advance of the last group.
        if (accept) begin
            ll_x_d  = snap_x;
            ur_x_d  = bus.box_R13S[1][0];
            ur_y_d  = bus.box_R13S[1][1];
            step_d  = new_step;
            cur_x_d = snap_x;
            cur_y_d = snap_y;
            if (box_empty) begin
                state_d = ST_WAIT;
            end else begin
                state_d = ST_TEST;
                tri_d   = bus.tri_R13S;
                color_d = bus.color_R13U;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SAMPS; gi++) begin : g_lane
            localparam wide_t LANE_OFS = wide_t'(gi);
            assign lane_x[gi] = sext(cur_x_d) + LANE_OFS * sext(step_d);
        end
    endgenerate

    // Output values for the group that will be displayed after this edge
    always_comb begin
        sample_d = sample_q;
        valid_d  = '0;
        last_d   = 1'b0;
        if (state_d == ST_TEST) begin
            for (int s = 0; s < SAMPS; s++) begin
                sample_d[s][0] = lane_x[s][SIGFIG-1:0];
                sample_d[s][1] = cur_y_d;
                valid_d[s]     = lane_x[s] <= sext(ur_x_d);
            end
            last_d = ((sext(cur_x_d) + grp_span(step_d)) > sext(ur_x_d)) &&
                     ((sext(cur_y_d) + sext(step_d)) > sext(ur_y_d));
        end
    end

    assign bus.halt_R13H      = halt;
    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign bus.sample_R14S    = sample_q;
    assign bus.validSamp_R14H = valid_q;
    assign bus.lastSamp_R14H  = last_q;
endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Directed bench for sample_iter_ctrl: inputs driven and outputs sampled on
// the falling edge; every expected group is hand-computed in the task tables.
module tb_sample_iter_ctrl;
    localparam int SIGFIG = 24;
    localparam int SAMPS  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sample_iter_ctrl_if bus ();
    sample_iter_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic start_tri(input int llx, input int lly, input int urx, input int ury,
                             input logic [1:0] ss, input int tag);
        bus.box_R13S[0][0] = SIGFIG'(llx);
        bus.box_R13S[0][1] = SIGFIG'(lly);
        bus.box_R13S[1][0] = SIGFIG'(urx);
        bus.box_R13S[1][1] = SIGFIG'(ury);
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                bus.tri_R13S[v][a] = SIGFIG'(tag * 100 + v * 10 + a);
        for (int c = 0; c < 3; c++)
            bus.color_R13U[c] = SIGFIG'(tag * 1000 + c);
        bus.ss_lg2_R13U   = ss;
        bus.validTri_R13H = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if (bus.validSamp_R14H !== 4'b0000 || bus.lastSamp_R14H !== 1'b0 || bus.halt_R13H !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: got valid=%b last=%b halt=%b want 0000/0/0",
                     bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H);
        end
        total++;
        if (bus.sample_R14S !== '0 || bus.tri_R14S !== '0 || bus.color_R14U !== '0) begin
            bad++;
            $display("FAIL reset_data: sample/tri/colour not zero (sample0 x=%0d)", bus.sample_R14S[0][0]);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.validSamp_R14H !== 4'b0000 || bus.halt_R13H !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got valid=%b halt=%b want 0000/0", bus.validSamp_R14H, bus.halt_R13H);
        end
        $display("reset: valid=%b last=%b halt=%b", bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H);
    endtask

    task automatic test_single_group;
        start_tri(0, 0, 1024, 0, 2'd0, 1);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        $display("single: x0=%0d y=%0d valid=%b last=%b halt=%b", $signed(bus.sample_R14S[0][0]),
                 $signed(bus.sample_R14S[0][1]), bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H);
        for (int s = 0; s < SAMPS; s++) begin
            total++;
            if (bus.sample_R14S[s][0] !== SIGFIG'(s * 1024) || bus.sample_R14S[s][1] !== SIGFIG'(0)) begin
                bad++;
                $display("FAIL single_pos lane%0d: got x=%0d y=%0d want x=%0d y=0", s,
                         $signed(bus.sample_R14S[s][0]), $signed(bus.sample_R14S[s][1]), s * 1024);
            end
        end
        total++;
        if (bus.validSamp_R14H !== 4'b0011 || bus.lastSamp_R14H !== 1'b1 || bus.halt_R13H !== 1'b0) begin
            bad++;
            $display("FAIL single_ctl: got valid=%b last=%b halt=%b want 0011/1/0",
                     bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H);
        end
        total++;
        if (bus.tri_R14S[2][1] !== SIGFIG'(121) || bus.color_R14U[2] !== SIGFIG'(1002)) begin
            bad++;
            $display("FAIL single_tri: got tri21=%0d col2=%0d want 121/1002", bus.tri_R14S[2][1], bus.color_R14U[2]);
        end
        @(negedge clk);
        total++;
        if (bus.validSamp_R14H !== 4'b0000 || bus.lastSamp_R14H !== 1'b0 || bus.halt_R13H !== 1'b0 ||
            bus.sample_R14S[3][0] !== SIGFIG'(3072)) begin
            bad++;
            $display("FAIL single_after: got valid=%b last=%b halt=%b x3=%0d want 0000/0/0/3072",
                     bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H, bus.sample_R14S[3][0]);
        end
    endtask

    task automatic test_row_wrap;
        int         ex [4] = '{1024, 5120, 1024, 5120};
        int         ey [4] = '{0, 0, 1024, 1024};
        logic [3:0] ev [4] = '{4'b1111, 4'b0001, 4'b1111, 4'b0001};
        logic       el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       eh [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        start_tri(1100, 0, 5120, 1024, 2'd0, 2);
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            bus.validTri_R13H = 1'b0;
            $display("wrap g%0d: x0=%0d y=%0d valid=%b last=%b halt=%b", g, $signed(bus.sample_R14S[0][0]),
                     $signed(bus.sample_R14S[0][1]), bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H);
            for (int s = 0; s < SAMPS; s++) begin
                total++;
                if (bus.sample_R14S[s][0] !== SIGFIG'(ex[g] + s * 1024) || bus.sample_R14S[s][1] !== SIGFIG'(ey[g])) begin
                    bad++;
                    $display("FAIL wrap_pos g%0d lane%0d: got x=%0d y=%0d want x=%0d y=%0d", g, s,
                             $signed(bus.sample_R14S[s][0]), $signed(bus.sample_R14S[s][1]), ex[g] + s * 1024, ey[g]);
                end
            end
            total++;
            if (bus.validSamp_R14H !== ev[g] || bus.lastSamp_R14H !== el[g] || bus.halt_R13H !== eh[g]) begin
                bad++;
                $display("FAIL wrap_ctl g%0d: got valid=%b last=%b halt=%b want %b/%b/%b", g,
                         bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H, ev[g], el[g], eh[g]);
            end
        end
        @(negedge clk);
        total++;
        if (bus.validSamp_R14H !== 4'b0000 || bus.halt_R13H !== 1'b0) begin
            bad++;
            $display("FAIL wrap_count: fifth cycle valid=%b halt=%b want 0000/0", bus.validSamp_R14H, bus.halt_R13H);
        end
    endtask

    task automatic test_stall;
        int         ex [4] = '{1024, 5120, 1024, 5120};
        int         ey [4] = '{0, 0, 1024, 1024};
        logic [3:0] ev [4] = '{4'b1111, 4'b0001, 4'b1111, 4'b0001};
        int         grp [7] = '{0, 1, 1, 1, 1, 2, 3};
        logic       stl [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        start_tri(1100, 0, 5120, 1024, 2'd0, 4);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.validTri_R13H = 1'b0;
            $display("stall obs%0d: x0=%0d y=%0d valid=%b last=%b halt=%b stall=%b", i,
                     $signed(bus.sample_R14S[0][0]), $signed(bus.sample_R14S[0][1]),
                     bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H, bus.stall_R14H);
            total++;
            if (bus.sample_R14S[0][0] !== SIGFIG'(ex[grp[i]]) || bus.sample_R14S[0][1] !== SIGFIG'(ey[grp[i]]) ||
                bus.validSamp_R14H !== ev[grp[i]]) begin
                bad++;
                $display("FAIL stall_grp obs%0d: got x0=%0d y=%0d valid=%b want x0=%0d y=%0d valid=%b", i,
                         $signed(bus.sample_R14S[0][0]), $signed(bus.sample_R14S[0][1]), bus.validSamp_R14H,
                         ex[grp[i]], ey[grp[i]], ev[grp[i]]);
            end
            total++;
            if (bus.halt_R13H !== (grp[i] != 3)) begin
                bad++;
                $display("FAIL stall_halt obs%0d: got %b want %b", i, bus.halt_R13H, grp[i] != 3);
            end
            bus.stall_R14H = stl[i];
        end
        @(negedge clk);
        total++;
        if (bus.validSamp_R14H !== 4'b0000) begin
            bad++;
            $display("FAIL stall_end: got valid=%b want 0000", bus.validSamp_R14H);
        end
    endtask

    task automatic test_back_to_back;
        int         ex [5] = '{1024, 5120, 1024, 5120, 0};
        int         ey [5] = '{0, 0, 1024, 1024, 0};
        logic [3:0] ev [5] = '{4'b1111, 4'b0001, 4'b1111, 4'b0001, 4'b0011};
        logic       el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       eh [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int         et [5] = '{200, 200, 200, 200, 300};
        start_tri(1100, 0, 5120, 1024, 2'd0, 2);
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            $display("b2b g%0d: x0=%0d y=%0d valid=%b last=%b halt=%b tri00=%0d", g,
                     $signed(bus.sample_R14S[0][0]), $signed(bus.sample_R14S[0][1]), bus.validSamp_R14H,
                     bus.lastSamp_R14H, bus.halt_R13H, bus.tri_R14S[0][0]);
            total++;
            if (bus.sample_R14S[1][0] !== SIGFIG'(ex[g] + 1024) || bus.sample_R14S[1][1] !== SIGFIG'(ey[g]) ||
                bus.tri_R14S[0][0] !== SIGFIG'(et[g])) begin
                bad++;
                $display("FAIL b2b_pos g%0d: got x1=%0d y=%0d tri00=%0d want x1=%0d y=%0d tri00=%0d", g,
                         $signed(bus.sample_R14S[1][0]), $signed(bus.sample_R14S[1][1]), bus.tri_R14S[0][0],
                         ex[g] + 1024, ey[g], et[g]);
            end
            total++;
            if (bus.validSamp_R14H !== ev[g] || bus.lastSamp_R14H !== el[g] || bus.halt_R13H !== eh[g]) begin
                bad++;
                $display("FAIL b2b_ctl g%0d: got valid=%b last=%b halt=%b want %b/%b/%b", g,
                         bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H, ev[g], el[g], eh[g]);
            end
            if (g == 0) start_tri(0, 0, 1024, 0, 2'd0, 3);
            if (g == 4) bus.validTri_R13H = 1'b0;
        end
        @(negedge clk);
        total++;
        if (bus.validSamp_R14H !== 4'b0000 || bus.halt_R13H !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got valid=%b halt=%b want 0000/0", bus.validSamp_R14H, bus.halt_R13H);
        end
    endtask

    task automatic test_empty;
        start_tri(2048, 0, 1024, 0, 2'd0, 6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.validTri_R13H = 1'b0;
            $display("empty obs%0d: valid=%b last=%b halt=%b", i, bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H);
            total++;
            if (bus.validSamp_R14H !== 4'b0000 || bus.lastSamp_R14H !== 1'b0 || bus.halt_R13H !== 1'b0) begin
                bad++;
                $display("FAIL empty obs%0d: got valid=%b last=%b halt=%b want 0000/0/0", i,
                         bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H);
            end
        end
    endtask

    task automatic test_negative;
        int         ex [2] = '{-3072, -1024};
        logic [3:0] ev [2] = '{4'b1111, 4'b0001};
        logic       el [2] = '{1'b0, 1'b1};
        logic       eh [2] = '{1'b1, 1'b0};
        start_tri(-3072, -1024, -1024, -1024, 2'd1, 7);
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            bus.validTri_R13H = 1'b0;
            $display("neg g%0d: x0=%0d y=%0d valid=%b last=%b halt=%b", g, $signed(bus.sample_R14S[0][0]),
                     $signed(bus.sample_R14S[0][1]), bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H);
            for (int s = 0; s < SAMPS; s++) begin
                total++;
                if (bus.sample_R14S[s][0] !== SIGFIG'(ex[g] + s * 512) || bus.sample_R14S[s][1] !== SIGFIG'(-1024)) begin
                    bad++;
                    $display("FAIL neg_pos g%0d lane%0d: got x=%0d y=%0d want x=%0d y=-1024", g, s,
                             $signed(bus.sample_R14S[s][0]), $signed(bus.sample_R14S[s][1]), ex[g] + s * 512);
                end
            end
            total++;
            if (bus.validSamp_R14H !== ev[g] || bus.lastSamp_R14H !== el[g] || bus.halt_R13H !== eh[g]) begin
                bad++;
                $display("FAIL neg_ctl g%0d: got valid=%b last=%b halt=%b want %b/%b/%b", g,
                         bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H, ev[g], el[g], eh[g]);
            end
        end
        @(negedge clk);
        total++;
        if (bus.validSamp_R14H !== 4'b0000) begin
            bad++;
            $display("FAIL neg_end: got valid=%b want 0000", bus.validSamp_R14H);
        end
    endtask

    task automatic test_reset_mid;
        start_tri(1100, 0, 5120, 1024, 2'd0, 5);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("midreset: valid=%b last=%b halt=%b", bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H);
        total++;
        if (bus.validSamp_R14H !== 4'b0000 || bus.lastSamp_R14H !== 1'b0 || bus.halt_R13H !== 1'b0 ||
            bus.sample_R14S !== '0 || bus.tri_R14S !== '0) begin
            bad++;
            $display("FAIL midreset_clear: got valid=%b last=%b halt=%b x0=%0d want all zero",
                     bus.validSamp_R14H, bus.lastSamp_R14H, bus.halt_R13H, bus.sample_R14S[0][0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.validSamp_R14H !== 4'b0000 || bus.halt_R13H !== 1'b0) begin
            bad++;
            $display("FAIL midreset_wait: got valid=%b halt=%b want 0000/0", bus.validSamp_R14H, bus.halt_R13H);
        end
        start_tri(0, 0, 1024, 0, 2'd0, 8);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        $display("restart: x1=%0d valid=%b last=%b", bus.sample_R14S[1][0], bus.validSamp_R14H, bus.lastSamp_R14H);
        total++;
        if (bus.validSamp_R14H !== 4'b0011 || bus.lastSamp_R14H !== 1'b1 || bus.sample_R14S[1][0] !== SIGFIG'(1024)) begin
            bad++;
            $display("FAIL midreset_restart: got valid=%b last=%b x1=%0d want 0011/1/1024",
                     bus.validSamp_R14H, bus.lastSamp_R14H, bus.sample_R14S[1][0]);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.tri_R13S      = '0;
        bus.color_R13U    = '0;
        bus.box_R13S      = '0;
        bus.ss_lg2_R13U   = 2'd0;
        bus.validTri_R13H = 1'b0;
        bus.stall_R14H    = 1'b0;
        test_reset;
        test_single_group;
        test_row_wrap;
        test_stall;
        test_back_to_back;
        test_empty;
        test_negative;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
